// File: rtl/lieat_clint_pkg.sv
// lieat_clint_pkg -- shared definitions for the core-local interruptor (CLINT).
//   XLEN              : bus data width
//   CSR_IDX           : width of a CSR index
//   CLINT_* offsets   : byte offsets of the CLINT registers from its base
//   clint_sel_e       : decoded register select used by the bus front end
//   byte_merge()      : applies a 4-bit byte enable to a 32-bit register value
package lieat_clint_pkg;

  localparam int XLEN    = 32;
  localparam int CSR_IDX = 12;

  localparam logic [15:0] CLINT_MSIP        = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

  typedef enum logic [2:0] {
    SEL_MSIP,
    SEL_MTIMECMP_LO,
    SEL_MTIMECMP_HI,
    SEL_MTIME_LO,
    SEL_MTIME_HI,
    SEL_NONE
  } clint_sel_e;

  // Replace the bytes of old_val whose enable bit is set with the matching
  // bytes of wdata; disabled bytes keep their old contents.
  function automatic logic [XLEN-1:0] byte_merge(input logic [XLEN-1:0] old_val,
                                                 input logic [XLEN-1:0] wdata,
                                                 input logic [3:0]      wmask);
    logic [XLEN-1:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wmask[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/lieat_clint_timer.sv
// lieat_clint_timer -- tick divider and 64-bit mtime counter.
//   clock  : clock
//   reset  : synchronous, active-low; clears divider and mtime
//   wr_lo  : bus write to mtime[31:0] this cycle
//   wr_hi  : bus write to mtime[63:32] this cycle
//   wdata  : value for the written half (byte enables already applied)
//   mtime  : current 64-bit time value
// The divider free-runs 0..TICK_DIV-1; mtime advances by one on each wrap.
// A bus write beats a coincident tick: the written half takes the write data,
// the other half is left alone and that tick is lost. The divider keeps
// counting through writes so the tick phase is never disturbed.
module lieat_clint_timer
  import lieat_clint_pkg::*;
#(
  parameter int TICK_DIV = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wr_lo,
  input  logic            wr_hi,
  input  logic [XLEN-1:0] wdata,
  output logic [63:0]     mtime
);

  localparam logic [7:0] DIV_LAST = 8'(TICK_DIV - 1);

  logic [7:0]  div_q;
  logic        tick;
  logic [63:0] mtime_q;

  assign tick  = (div_q == DIV_LAST);
  assign mtime = mtime_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      div_q   <= '0;
      mtime_q <= '0;
    end else begin
      div_q <= tick ? 8'd0 : div_q + 8'd1;
      if (wr_lo) begin
        mtime_q[31:0] <= wdata;
      end else if (wr_hi) begin
        mtime_q[63:32] <= wdata;
      end else if (tick) begin
        mtime_q <= mtime_q + 64'd1;
      end
    end
  end

endmodule

// File: rtl/lieat_general_dfflr.sv
// lieat_general_dfflr -- load-enabled flop with synchronous active-low reset to 0.
//   clock : clock
//   reset : synchronous, active-low; clears qout
//   lden  : load enable
//   dnxt  : next value, captured when lden is high
//   qout  : registered value
module lieat_general_dfflr #(
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      qout <= '0;
    end else if (lden) begin
      qout <= dnxt;
    end
  end

endmodule

// File: rtl/lieat_general_dfflrd.sv
// lieat_general_dfflrd -- load-enabled flop with synchronous active-low reset
// to a configurable value RST_VAL.
//   clock : clock
//   reset : synchronous, active-low; loads RST_VAL
//   lden  : load enable
//   dnxt  : next value, captured when lden is high
//   qout  : registered value
module lieat_general_dfflrd #(
  parameter int          DW      = 32,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      qout <= RST_VAL;
    end else if (lden) begin
      qout <= dnxt;
    end
  end

endmodule

// File: rtl/lieat_clint.sv
// lieat_clint -- core-local interruptor: msip, mtimecmp and mtime behind a
// simple valid/ready command/response port, plus the two interrupt levels.
//   clock, reset            : clock; synchronous active-low reset
//   cmd_valid/cmd_ready     : command handshake
//   cmd_read                : 1 = read, 0 = write
//   cmd_addr                : byte offset from the CLINT base
//   cmd_wdata/cmd_wmask     : write data and byte enables
//   rsp_valid/rsp_ready     : response handshake (one response outstanding max)
//   rsp_rdata               : read data, 0 for writes and errors
//   rsp_err                 : misaligned or unmapped offset
//   clint_time_irq          : mtime >= mtimecmp (unsigned, 64-bit)
//   clint_msip_irq          : msip bit 0
module lieat_clint
  import lieat_clint_pkg::*;
#(
  parameter int TICK_DIV = 8,
  parameter int ADDR_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_read,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [XLEN-1:0]   cmd_wdata,
  input  logic [3:0]        cmd_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              clint_time_irq,
  output logic              clint_msip_irq
);

  logic            accept;
  logic            addr_err;
  logic            wr_ok;
  clint_sel_e      sel;
  logic [XLEN-1:0] rd_data;

  logic            msip_q;
  logic [XLEN-1:0] mtimecmp_lo_q;
  logic [XLEN-1:0] mtimecmp_hi_q;
  logic [63:0]     mtime;

  logic            time_wr_lo;
  logic            time_wr_hi;
  logic [XLEN-1:0] time_wdata;

  // A new command may enter while the previous response leaves in the same cycle.
  assign cmd_ready = ~rsp_valid | rsp_ready;
  assign accept    = cmd_valid & cmd_ready;

  // Offset decode; any nonzero low address bits make the access an error.
  always_comb begin
    sel = SEL_NONE;
    if (cmd_addr[1:0] == 2'b00) begin
      if (cmd_addr == ADDR_W'(CLINT_MSIP))             sel = SEL_MSIP;
      else if (cmd_addr == ADDR_W'(CLINT_MTIMECMP_LO)) sel = SEL_MTIMECMP_LO;
      else if (cmd_addr == ADDR_W'(CLINT_MTIMECMP_HI)) sel = SEL_MTIMECMP_HI;
      else if (cmd_addr == ADDR_W'(CLINT_MTIME_LO))    sel = SEL_MTIME_LO;
      else if (cmd_addr == ADDR_W'(CLINT_MTIME_HI))    sel = SEL_MTIME_HI;
    end
  end

  assign addr_err = (sel == SEL_NONE);
  assign wr_ok    = accept & ~cmd_read & ~addr_err;

  always_comb begin
    rd_data = '0;
    case (sel)
      SEL_MSIP:        rd_data = {{(XLEN-1){1'b0}}, msip_q};
      SEL_MTIMECMP_LO: rd_data = mtimecmp_lo_q;
      SEL_MTIMECMP_HI: rd_data = mtimecmp_hi_q;
      SEL_MTIME_LO:    rd_data = mtime[31:0];
      SEL_MTIME_HI:    rd_data = mtime[63:32];
      default:         rd_data = '0;
    endcase
  end

  // msip implements only bit 0, so only byte lane 0 can change it.
  lieat_general_dfflr #(.DW(1)) u_msip (
    .clock (clock),
    .reset (reset),
    .lden  (wr_ok & (sel == SEL_MSIP) & cmd_wmask[0]),
    .dnxt  (cmd_wdata[0]),
    .qout  (msip_q)
  );

  // mtimecmp resets to all ones so the timer interrupt stays quiet until
  // software programs a compare value.
  lieat_general_dfflrd #(.DW(XLEN), .RST_VAL({XLEN{1'b1}})) u_mtimecmp_lo (
    .clock (clock),
    .reset (reset),
    .lden  (wr_ok & (sel == SEL_MTIMECMP_LO)),
    .dnxt  (byte_merge(mtimecmp_lo_q, cmd_wdata, cmd_wmask)),
    .qout  (mtimecmp_lo_q)
  );

  lieat_general_dfflrd #(.DW(XLEN), .RST_VAL({XLEN{1'b1}})) u_mtimecmp_hi (
    .clock (clock),
    .reset (reset),
    .lden  (wr_ok & (sel == SEL_MTIMECMP_HI)),
    .dnxt  (byte_merge(mtimecmp_hi_q, cmd_wdata, cmd_wmask)),
    .qout  (mtimecmp_hi_q)
  );

  assign time_wr_lo = wr_ok & (sel == SEL_MTIME_LO);
  assign time_wr_hi = wr_ok & (sel == SEL_MTIME_HI);
  assign time_wdata = (sel == SEL_MTIME_HI) ? byte_merge(mtime[63:32], cmd_wdata, cmd_wmask)
                                            : byte_merge(mtime[31:0],  cmd_wdata, cmd_wmask);

  lieat_clint_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clock (clock),
    .reset (reset),
    .wr_lo (time_wr_lo),
    .wr_hi (time_wr_hi),
    .wdata (time_wdata),
    .mtime (mtime)
  );

  // Response registers: valid sets on acceptance and clears once consumed;
  // data and error only load on acceptance so they hold while stalled.
  lieat_general_dfflr #(.DW(1)) u_rsp_valid (
    .clock (clock),
    .reset (reset),
    .lden  (accept | rsp_ready),
    .dnxt  (accept),
    .qout  (rsp_valid)
  );

  lieat_general_dfflr #(.DW(XLEN)) u_rsp_rdata (
    .clock (clock),
    .reset (reset),
    .lden  (accept),
    .dnxt  (cmd_read ? rd_data : '0),
    .qout  (rsp_rdata)
  );

  lieat_general_dfflr #(.DW(1)) u_rsp_err (
    .clock (clock),
    .reset (reset),
    .lden  (accept),
    .dnxt  (addr_err),
    .qout  (rsp_err)
  );

  assign clint_time_irq = (mtime >= {mtimecmp_hi_q, mtimecmp_lo_q});
  assign clint_msip_irq = msip_q;

endmodule
